// File: rtl/fetch_pc_unit.sv
//==============================================================================
// Module   : fetch_pc_unit
// Brief    : Program counter plus 2-entry {pc, instr} buffer feeding decode.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        misalign_err
);

    localparam logic [1:0]  c_DEPTH = 2'(BUF_DEPTH);
    localparam logic [31:0] c_NOP   = 32'h0000_0013;

    generate
        if (BUF_DEPTH != 2) begin : g_depth_check
            $error("fetch_pc_unit: only BUF_DEPTH = 2 is supported");
        end
    endgenerate

    logic [31:0] pc_q,   pc_d;
    logic [1:0]  cnt_q,  cnt_d;
    logic [31:0] pc0_q,  pc0_d;
    logic [31:0] ins0_q, ins0_d;
    logic [31:0] pc1_q,  pc1_d;
    logic [31:0] ins1_q, ins1_d;
    logic        mis_q,  mis_d;

    logic        w_push;
    logic        w_pop;
    logic [1:0]  w_keep;

    assign imem_addr = pc_q;
    assign id_valid  = (cnt_q != 2'd0);
    assign id_instr  = id_valid ? ins0_q : c_NOP;
    assign id_pc     = id_valid ? pc0_q  : 32'h0000_0000;
    assign misalign_err = mis_q;

    assign w_pop  = id_valid & id_ready & ~redirect_valid;
    assign w_push = fetch_en & ~redirect_valid & ((cnt_q < c_DEPTH) | w_pop);
    // Occupancy after the pop; the new word lands at this slot.
    assign w_keep = cnt_q - {1'b0, w_pop};

    always_comb begin
        pc_d   = pc_q;
        cnt_d  = cnt_q;
        pc0_d  = pc0_q;
        ins0_d = ins0_q;
        pc1_d  = pc1_q;
        ins1_d = ins1_q;
        mis_d  = mis_q;

        if (redirect_valid) begin
            cnt_d = 2'd0;
            pc_d  = {redirect_pc[31:2], 2'b00};
            if (redirect_pc[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
        end else begin
            if (w_pop) begin
                pc0_d  = pc1_q;
                ins0_d = ins1_q;
            end
            if (w_push) begin
                if (w_keep == 2'd0) begin
                    pc0_d  = pc_q;
                    ins0_d = imem_rdata;
                end else begin
                    pc1_d  = pc_q;
                    ins1_d = imem_rdata;
                end
                pc_d = pc_q + 32'd4;
            end
            cnt_d = w_keep + {1'b0, w_push};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= RESET_PC;
            cnt_q  <= 2'd0;
            pc0_q  <= 32'h0000_0000;
            ins0_q <= c_NOP;
            pc1_q  <= 32'h0000_0000;
            ins1_q <= c_NOP;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            cnt_q  <= cnt_d;
            pc0_q  <= pc0_d;
            ins0_q <= ins0_d;
            pc1_q  <= pc1_d;
            ins1_q <= ins1_d;
            mis_q  <= mis_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_unit.sv
//==============================================================================
// Module   : tb_fetch_pc_unit
// Brief    : Self-checking bench for fetch_pc_unit against a queue-based model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_fetch_pc_unit;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        misalign_err;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic        m_mis;

    fetch_pc_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .misalign_err   (misalign_err)
    );

    // Memory holds word k at byte address 4k.
    assign imem_rdata = imem_addr >> 2;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc  = 32'h0000_0000;
        m_mis = 1'b0;
    endtask

    task automatic check_model();
        chk("imem_addr", imem_addr, m_pc);
        chk("id_valid", {31'd0, id_valid}, {31'd0, m_q.size() != 0});
        chk("id_pc", id_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
        chk("id_instr", id_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h13);
        chk("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    endtask

    task automatic check_reset_vals();
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_instr", id_instr, 32'h13);
        chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    endtask

    // Called shortly after a rising edge: drive, check at falling edge, advance model.
    task automatic cycle(input logic fe, input logic rv, input logic [31:0] rpc, input logic rdy);
        logic do_pop, do_push;
        fetch_en       = fe;
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(negedge clk);
        check_model();
        do_pop  = (m_q.size() != 0) && rdy && !rv;
        do_push = fe && !rv && ((m_q.size() < 2) || do_pop);
        if (rv) begin
            m_q.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (rpc[1:0] != 2'b00) m_mis = 1'b1;
        end else begin
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                m_q.push_back('{pc: m_pc, instr: m_pc >> 2});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        fetch_en       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        model_reset();
        #3;
        check_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Streaming from reset
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Back-pressure from a fresh start
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_addr", imem_addr, 32'h8);
        chk("stall_pc", id_pc, 32'h0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Redirect while full
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        cycle(1'b1, 1'b1, 32'h100, 1'b0);
        chk("redir_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_addr", imem_addr, 32'h100);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_pc", id_pc, 32'h100);
        cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Misaligned redirect, sticky flag
        cycle(1'b1, 1'b1, 32'h203, 1'b1);
        chk("mis_addr", imem_addr, 32'h200);
        chk("mis_flag", {31'd0, misalign_err}, 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // Address wrap
        cycle(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 32'h0, 1'b1);

        // fetch_en low holds pc, pops drain
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset pulse between edges while full
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 32'h0, 1'b0);
        #1 rst = 1'b1;
        #1 check_reset_vals();
        #1 rst = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b1);
        chk("post_rst_pc", id_pc, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic        fe, rv, rdy;
            logic [31:0] rpc;
            fe  = ($urandom_range(0, 9) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_FFFC);
            if ($urandom_range(0, 9) == 0) rpc[1:0] = 2'($urandom);
            cycle(fe, rv, rpc, rdy);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries; only value 2 supported.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fetch_en  input  1  when 1, fetch permitted; when 0, PC holds and no pushes occur.
REQ-006 SHALL have port imem_addr  output  32  byte address to instruction memory, combinational from PC register.
REQ-007 SHALL have port imem_rdata  input  32  instruction word; combinational (same-cycle) read of imem_addr.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump/trap redirect request.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port id_valid  output  1  buffer head holds a valid instruction.
REQ-011 SHALL have port id_ready  input  1  decode accepts the head this cycle.
REQ-012 SHALL have port id_instr  output  32  head instruction word.
REQ-013 SHALL have port id_pc  output  32  head instruction address.
REQ-014 SHALL have port misalign_err  output  1  sticky flag: a redirect target had nonzero bits [1:0].

Function
REQ-015 SHALL hold PC register pc_q; imem_addr = pc_q with no register stage.
REQ-016 SHALL keep a 2-entry FIFO of {pc, instr} pairs with a count of 0..2.
REQ-017 SHALL define push = fetch_en & ~redirect_valid & (count<2 | pop); pop = id_valid & id_ready & ~redirect_valid.
REQ-018 SHALL, on push, write {pc_q, imem_rdata} at the tail and set pc_q <= pc_q + 4 at the same edge.
REQ-019 SHALL compute pc_q + 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-020 SHALL support simultaneous push and pop with count unchanged, the new entry landing behind the remaining one.
REQ-021 SHALL hold pc_q and FIFO contents when full (count=2) and pop=0; fetch_en=0 holds pc_q and allows pops.
REQ-022 SHALL drive id_valid = (count!=0); id_instr/id_pc from head when valid, else 32'h0000_0013 and 32'h0.
REQ-023 SHALL give fetch-to-decode latency of 1 cycle: a word pushed at edge N is visible at the head after edge N.
REQ-024 SHALL, on redirect_valid at an edge, set count to 0, discard all entries, and load pc_q <= {redirect_pc[31:2], 2'b00}; redirect has priority over push and pop.
REQ-025 SHALL set misalign_err to 1 on any redirect with redirect_pc[1:0]!=0; it clears only on rst.
REQ-026 SHALL hold id_instr and id_pc stable while id_valid=1 and id_ready=0.

Reset
REQ-027 SHALL, on rst assertion, immediately and asynchronously set pc_q=RESET_PC, count=0, misalign_err=0, id_valid=0, id_instr=32'h0000_0013, and id_pc=0.
REQ-028 SHALL abandon any in-flight redirect or push on reset assertion mid-operation, with no entry surviving.
REQ-029 SHALL, on the first clk edge after rst deasserts with fetch_en=1, push the word at RESET_PC.

Verification
REQ-030 SHALL be checked with this stimulus and response: reset release, fetch_en=1, id_ready=1, memory word k=k -> id_pc sequence 0,4,8,... each cycle, id_instr=0,1,2,..., id_valid high from cycle 1.
REQ-031 SHALL be checked with this stimulus and response: id_ready=0 for 5 cycles -> count saturates at 2, imem_addr frozen at 8, id_pc stays 0, and after release entries 0,4,8 come out in order.
REQ-032 SHALL be checked with this stimulus and response: redirect_valid with redirect_pc=32'h100 while count=2 -> next cycle id_valid=0, imem_addr=32'h100, following cycle id_pc=32'h100.
REQ-033 SHALL be checked with this stimulus and response: redirect_pc=32'h203 -> imem_addr=32'h200 and misalign_err=1, which persists until rst.
REQ-034 SHALL be checked with this stimulus and response: redirect to 32'hFFFF_FFFC with streaming -> id_pc sequence FFFF_FFFC, 0000_0000, 0000_0004.
REQ-035 SHALL be checked with this stimulus and response: rst pulsed between edges while count=2 -> outputs take reset values before the next edge, and the first post-reset id_pc equals RESET_PC.
